// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: operand/result bundle between the execute stage and the HI/LO unit
interface hilo_muldiv_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALULo;
  logic [31:0] ALUHi;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  modport master (output Start, Op, A, B, ALULo, ALUHi, input Hi, Lo, Busy, Done);
  modport slave (input Start, Op, A, B, ALULo, ALUHi, output Hi, Lo, Busy, Done);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO pair with MULT/MT/MADD/MSUB writes and a 1-bit/cycle restoring divider; HILO_FORWARD_EN forwards same-cycle HI/LO writes
module hilo_muldiv_unit #(
  parameter int DIV_CYCLES = 32
) (
  input logic Clk,
  input logic Reset,
  hilo_muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIV, FIXUP} state_t;
  state_t state, state_nxt;
  logic [31:0] hi_q, lo_q, hi_wr, lo_wr, a_q, dvs, quo, rem, mag_a, mag_b;
  logic [4:0] cnt;
  logic qneg, rneg, done_q, start_div;
  logic [32:0] shf, sub;
  logic [63:0] acc_add, acc_sub;
  assign start_div = state == IDLE && bus.Start && bus.Op[2:1] == 2'b10;
  assign mag_a = (!bus.Op[0] && bus.A[31]) ? -bus.A : bus.A;
  assign mag_b = (!bus.Op[0] && bus.B[31]) ? -bus.B : bus.B;
  assign shf = {rem, quo[31]};
  assign sub = shf - {1'b0, dvs};
  assign acc_add = {hi_q, lo_q} + {bus.ALUHi, bus.ALULo};
  assign acc_sub = {hi_q, lo_q} - {bus.ALUHi, bus.ALULo};
  // Value HI/LO take from an IDLE-state instruction; divides are handled by the datapath
  always_comb begin
    hi_wr = hi_q;
    lo_wr = lo_q;
    if (state == IDLE && bus.Start && !Reset)
      case (bus.Op)
        3'b001: {hi_wr, lo_wr} = {bus.ALUHi, bus.ALULo};
        3'b010: hi_wr = bus.A;
        3'b011: lo_wr = bus.A;
        3'b110: {hi_wr, lo_wr} = acc_add;
        3'b111: {hi_wr, lo_wr} = acc_sub;
        default: ;
      endcase
  end
  // Next state: IDLE -> DIV on a divide, DIV for DIV_CYCLES iterations, one FIXUP cycle
  always_comb begin
    state_nxt = state == IDLE ? (start_div ? DIV : IDLE)
              : state == DIV ? (cnt == 5'(DIV_CYCLES - 1) ? FIXUP : DIV)
              : IDLE;
  end
  // State register; reset aborts any divide in flight
  always_ff @(posedge Clk) begin
    state <= Reset ? IDLE : state_nxt;
  end
  // HI/LO registers and divider datapath
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      cnt <= '0;
    end else begin
      done_q <= state == FIXUP;
      if (state == FIXUP) begin
        hi_q <= dvs == '0 ? a_q : (rneg ? -rem : rem);
        lo_q <= dvs == '0 ? '1 : (qneg ? -quo : quo);
      end else begin
        hi_q <= hi_wr;
        lo_q <= lo_wr;
      end
      if (start_div) begin
        a_q <= bus.A;
        dvs <= mag_b;
        quo <= mag_a;
        rem <= '0;
        cnt <= '0;
        qneg <= !bus.Op[0] && (bus.A[31] ^ bus.B[31]);
        rneg <= !bus.Op[0] && bus.A[31];
      end else if (state == DIV) begin
        rem <= sub[32] ? shf[31:0] : sub[31:0];
        quo <= {quo[30:0], !sub[32]};
        cnt <= cnt + 5'd1;
      end
    end
  end
  assign bus.Busy = state != IDLE;
  assign bus.Done = done_q;
`ifdef HILO_FORWARD_EN
  assign bus.Hi = hi_wr;
  assign bus.Lo = lo_wr;
`else
  assign bus.Hi = hi_q;
  assign bus.Lo = lo_q;
`endif
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage companion to the 32-bit ALU; owns the architectural HI/LO register pair.
- Captures the ALU's 64-bit multiply result as {HiResult, ALUResult} and performs MTHI/MTLO, MADD/MSUB accumulation, and DIV/DIVU.
- DIV/DIVU use an iterative 1-bit/cycle restoring divider.
- Asserts Busy so the hazard unit stalls the pipeline while a divide is in flight; MFHI/MFLO read the Hi/Lo outputs.

Parameters:
- DIV_CYCLES, 32, number of quotient iterations; fixed at data width, not user-tunable below 32.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  qualifies Op for one cycle
- Op  input  3  000 nop, 001 MULT-write, 010 MTHI, 011 MTLO, 100 DIV, 101 DIVU, 110 MADD, 111 MSUB
- A  input  32  rs operand (dividend / MT source)
- B  input  32  rt operand (divisor)
- ALULo  input  32  low product word from ALU
- ALUHi  input  32  high product word from ALU
- Hi  output  32  HI register
- Lo  output  32  LO register
- Busy  output  1  divide in progress; stall request
- Done  output  1  one-cycle pulse when a divide result is written

Behaviour:
- Reset (sync, active-high) has priority over everything:
  - Hi=0, Lo=0, Busy=0, Done=0.
  - FSM returns to IDLE; any in-flight divide is aborted with no write.
- FSM states: IDLE, DIV, FIXUP.
- IDLE, Start=1, Op selects the action; all HI/LO writes land on the next rising edge:
  - 001: Hi<=ALUHi, Lo<=ALULo.
  - 010: Hi<=A.
  - 011: Lo<=A.
  - 110: {Hi,Lo} <= {Hi,Lo} + {ALUHi,ALULo}, 64-bit, wrap modulo 2^64.
  - 111: {Hi,Lo} <= {Hi,Lo} - {ALUHi,ALULo}, 64-bit, wrap modulo 2^64.
  - 100/101: latch operands; take magnitudes for 100 and record quotient sign (A[31]^B[31]) and remainder sign (A[31]); go to DIV with Busy=1 from the next cycle.
  - 000: no effect.
- DIV: one restoring iteration per cycle, DIV_CYCLES cycles; iteration counter counts 0..31; then go to FIXUP.
- FIXUP, one cycle:
  - Apply signs; Lo<=quotient, Hi<=remainder on the edge ending FIXUP.
  - Done=1 for exactly that following cycle; Busy=0 in the same cycle; FSM back to IDLE.
- Latency: Start at cycle 0 -> Busy high cycles 1..33 -> Hi/Lo updated and Done=1 in cycle 34.
- Start while Busy=1 is ignored entirely; any Op, including MT and MULT, is dropped. Upstream must hold the instruction via the stall.
- Hi/Lo are stable (previous values) throughout DIV/FIXUP.
- Boundary conditions, same latency and same Done timing:
  - Divide by zero, both ops: Lo=32'hFFFFFFFF, Hi=A.
  - Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: Lo=32'h80000000, Hi=0.
- Signed DIV: quotient truncates toward zero; remainder takes the dividend's sign.
- Start and Reset in the same cycle: Reset wins; no write.

Optional Feature:
- Macro: HILO_FORWARD_EN.
- Defined: Hi/Lo outputs forward the value being written this cycle when the IDLE-state Start/Op writes HI or LO. MFHI/MFLO in the cycle of the MT/MULT/MADD/MSUB then see the new value.
  - 001, 110, 111: forward Hi and Lo.
  - 010: forward Hi only.
  - 011: forward Lo only.
  - Divide results are never forwarded; they appear with Done.
- Undefined: Hi/Lo are purely registered; new value visible one cycle after Start.

Test Plan:
- Reset mid-divide: DIV A=100, B=7, assert Reset at cycle 10 -> Hi=0, Lo=0, Busy=0 next cycle; Done never pulses.
- DIVU A=100, B=7 -> Busy cycles 1..33; cycle 34: Lo=14, Hi=2, Done=1 for one cycle.
- DIV A=-7 (0xFFFFFFF9), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=0x12345678, B=0 -> Lo=0xFFFFFFFF, Hi=0x12345678 at cycle 34.
- MULT-write ALUHi=1, ALULo=0xFFFFFFFF, then MADD ALUHi=0, ALULo=1 -> Hi=2, Lo=0. Then MSUB ALUHi=0, ALULo=1 -> Hi=1, Lo=0xFFFFFFFF.
- MTHI A=5 issued at cycle 3 while a DIV is busy -> ignored; Hi ends as the divide remainder. Under HILO_FORWARD_EN: MTLO A=9 in IDLE -> Lo=9 in the same cycle; without the macro, Lo=9 one cycle later.
